// File: rtl/adder_fp32.sv
// Single-cycle IEEE-754 binary32 adder/subtractor with round-to-nearest-even and flush-to-zero.
// Define ADDER_SPECIALS_EN to add NaN/Inf handling; otherwise exponent 0xFF is treated as finite.
module adder_fp32 (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] OP_A,
    input  logic [31:0] OP_B,
    input  logic        OP,
    input  logic        IN_VALID,
    output logic [31:0] IEEE_FORMAT,
    output logic        OUT_VALID
);

    // Handshake: IN_VALID=1 at a rising CLK captures OP_A/OP_B/OP; the result is on
    // IEEE_FORMAT with OUT_VALID=1 right after that edge. There is no ready/back-pressure,
    // and when IN_VALID=0 OUT_VALID drops while IEEE_FORMAT keeps its last value.

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + 5'd1;
            end
        end
        return n;
    endfunction

    logic        w_sa, w_sb;
    logic [7:0]  w_ea, w_eb;
    logic [22:0] w_fa, w_fb;
    logic        w_a_zero, w_b_zero;

    assign w_sa     = OP_A[31];
    assign w_ea     = OP_A[30:23];
    assign w_fa     = OP_A[22:0];
    assign w_sb     = OP_B[31] ^ OP;
    assign w_eb     = OP_B[30:23];
    assign w_fb     = OP_B[22:0];
    assign w_a_zero = (w_ea == 8'd0);
    assign w_b_zero = (w_eb == 8'd0);

    // Order by magnitude so L is always the larger operand.
    logic        w_swap;
    logic        w_sl;
    logic [7:0]  w_el, w_es;
    logic [23:0] w_ml, w_ms;

    assign w_swap = {w_eb, w_fb} > {w_ea, w_fa};
    assign w_sl   = w_swap ? w_sb : w_sa;
    assign w_el   = w_swap ? w_eb : w_ea;
    assign w_es   = w_swap ? w_ea : w_eb;
    assign w_ml   = {1'b1, (w_swap ? w_fb : w_fa)};
    assign w_ms   = {1'b1, (w_swap ? w_fa : w_fb)};

    // Alignment: 24-bit mantissa followed by guard, round and sticky.
    logic [7:0]  w_de;
    logic [51:0] w_wide;
    logic [26:0] w_s_al;
    logic [26:0] w_l_al;

    assign w_de   = w_el - w_es;
    assign w_wide = {w_ms, 28'd0} >> w_de;
    assign w_s_al = (w_de >= 8'd26) ? 27'd1 : {w_wide[51:26], |w_wide[25:0]};
    assign w_l_al = {w_ml, 3'b000};

    logic        w_eff_sub;
    logic [27:0] w_sum;
    logic [26:0] w_dif;
    logic [4:0]  w_lz;

    assign w_eff_sub = w_sa ^ w_sb;
    assign w_sum     = {1'b0, w_l_al} + {1'b0, w_s_al};
    assign w_dif     = w_l_al - w_s_al;
    assign w_lz      = lzc27(w_dif);

    logic [26:0]        w_norm;
    logic signed [9:0]  w_exp;

    always_comb begin
        w_norm = w_sum[26:0];
        w_exp  = $signed({2'b00, w_el});
        if (w_eff_sub) begin
            w_norm = w_dif << w_lz;
            w_exp  = $signed({2'b00, w_el}) - $signed({5'd0, w_lz});
        end else if (w_sum[27]) begin
            w_norm = {w_sum[27:2], w_sum[1] | w_sum[0]};
            w_exp  = $signed({2'b00, w_el}) + 10'sd1;
        end
    end

    // Round to nearest, ties to even; a carry out of the mantissa bumps the exponent.
    logic               w_rnd_up;
    logic [24:0]        w_mant_r;
    logic signed [9:0]  w_exp_r;
    logic [22:0]        w_frac_r;

    assign w_rnd_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    assign w_mant_r = {1'b0, w_norm[26:3]} + {24'd0, w_rnd_up};
    assign w_exp_r  = w_mant_r[24] ? (w_exp + 10'sd1) : w_exp;
    assign w_frac_r = w_mant_r[24] ? w_mant_r[23:1] : w_mant_r[22:0];

`ifdef ADDER_SPECIALS_EN
    logic w_a_max, w_b_max;
    logic w_a_nan, w_b_nan, w_a_inf, w_b_inf;

    assign w_a_max = (w_ea == 8'hFF);
    assign w_b_max = (w_eb == 8'hFF);
    assign w_a_nan = w_a_max && (w_fa != 23'd0);
    assign w_b_nan = w_b_max && (w_fb != 23'd0);
    assign w_a_inf = w_a_max && (w_fa == 23'd0);
    assign w_b_inf = w_b_max && (w_fb == 23'd0);
`endif

    logic [31:0] w_result;

    always_comb begin
        w_result = {w_sl, w_exp_r[7:0], w_frac_r};
        if (w_eff_sub && (w_dif == 27'd0)) begin
            w_result = 32'h0000_0000;
        end else if (w_exp_r < 10'sd1) begin
            w_result = 32'h0000_0000;
        end else if (w_exp_r > 10'sd254) begin
            w_result = {w_sl, 8'hFF, 23'd0};
        end

        // Zero (and denormal) operands pass the other operand through unchanged.
        if (w_a_zero && w_b_zero) begin
            w_result = {w_sa & w_sb, 31'd0};
        end else if (w_a_zero) begin
            w_result = {w_sb, OP_B[30:0]};
        end else if (w_b_zero) begin
            w_result = {w_sa, OP_A[30:0]};
        end

`ifdef ADDER_SPECIALS_EN
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_sa != w_sb))) begin
            w_result = 32'h7FC0_0000;
        end else if (w_a_inf) begin
            w_result = {w_sa, 8'hFF, 23'd0};
        end else if (w_b_inf) begin
            w_result = {w_sb, 8'hFF, 23'd0};
        end
`endif
    end

    logic [31:0] r_result;
    logic        r_valid;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_result <= 32'h0000_0000;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= IN_VALID;
            if (IN_VALID) begin
                r_result <= w_result;
            end
        end
    end

    assign IEEE_FORMAT = r_result;
    assign OUT_VALID   = r_valid;

endmodule

// File: tb/tb_adder_fp32.sv
// Bench for adder_fp32: directed corner vectors plus random operands checked against
// a real-arithmetic reference (double sum, then round-to-nearest-even into binary32).
module tb_adder_fp32;

    logic        CLK;
    logic        RST;
    logic [31:0] OP_A;
    logic [31:0] OP_B;
    logic        OP;
    logic        IN_VALID;
    logic [31:0] IEEE_FORMAT;
    logic        OUT_VALID;

    adder_fp32 dut (
        .CLK        (CLK),
        .RST        (RST),
        .OP_A       (OP_A),
        .OP_B       (OP_B),
        .OP         (OP),
        .IN_VALID   (IN_VALID),
        .IEEE_FORMAT(IEEE_FORMAT),
        .OUT_VALID  (OUT_VALID)
    );

    // Clock and watchdog
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog");
    end

    // Scoreboard state
    logic [31:0] exp_q[$];
    logic [31:0] last_res;
    int          n_vectors = 0;
    int          n_miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Reference model: binary32 -> double, exact-enough double add, RNE back to binary32.
    function automatic logic [63:0] f2d(input logic [31:0] x);
        if (x[30:23] == 8'd0) return {x[31], 63'd0};
        return {x[31], ({3'b000, x[30:23]} + 11'd896), x[22:0], 29'd0};
    endfunction

    function automatic logic [31:0] d2f(input logic [63:0] d);
        logic [23:0] keep;
        logic [28:0] rest;
        int          e;
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        e    = int'({21'd0, d[62:52]}) - 896;
        keep = {1'b0, d[51:29]};
        rest = d[28:0];
        if ((rest > 29'h1000_0000) || ((rest == 29'h1000_0000) && keep[0])) keep = keep + 24'd1;
        if (keep[23]) begin
            keep = 24'd0;
            e    = e + 1;
        end
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        if (e <= 0) return 32'h0000_0000;
        return {d[63], e[7:0], keep[22:0]};
    endfunction

    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic op);
        logic [31:0] bb;
        real         ra;
        real         rb;
        bb = {b[31] ^ op, b[30:0]};
`ifdef ADDER_SPECIALS_EN
        begin
            logic a_nan, b_nan, a_inf, b_inf;
            a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
            b_nan = (bb[30:23] == 8'hFF) && (bb[22:0] != 23'd0);
            a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
            b_inf = (bb[30:23] == 8'hFF) && (bb[22:0] == 23'd0);
            if (a_nan || b_nan) return 32'h7FC0_0000;
            if (a_inf && b_inf) return (a[31] == bb[31]) ? {a[31], 8'hFF, 23'd0} : 32'h7FC0_0000;
            if (a_inf) return {a[31], 8'hFF, 23'd0};
            if (b_inf) return {bb[31], 8'hFF, 23'd0};
        end
`endif
        ra = $bitstoreal(f2d(a));
        rb = $bitstoreal(f2d(bb));
        return d2f($realtobits(ra + rb));
    endfunction

    function automatic logic [31:0] rand_fp(input int lo, input int hi);
        logic [31:0] x;
        int          e;
        x = $urandom;
        e = int'($urandom_range(hi, lo));
        x[30:23] = e[7:0];
        return x;
    endfunction

    // Driver tasks: one operation per cycle, result sampled 1 time unit after the edge.
    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic op,
                         input logic [31:0] exp, input string tag);
        @(negedge CLK);
        OP_A     = a;
        OP_B     = b;
        OP       = op;
        IN_VALID = 1'b1;
        exp_q.push_back(exp);
        @(posedge CLK);
        #1;
        check({tag, ".valid"}, {31'd0, OUT_VALID}, 32'd1);
        check(tag, IEEE_FORMAT, exp_q.pop_front());
        last_res = exp;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            IN_VALID = 1'b0;
            OP_A     = $urandom;
            OP_B     = $urandom;
            OP       = 1'b0;
            @(posedge CLK);
            #1;
            check("idle.valid", {31'd0, OUT_VALID}, 32'd0);
            check("idle.hold", IEEE_FORMAT, last_res);
        end
    endtask

    task automatic apply_ref(input logic [31:0] a, input logic [31:0] b, input logic op, input string tag);
        apply(a, b, op, ref_add(a, b, op), tag);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        int          k;
        int          e;

        RST      = 1'b0;
        IN_VALID = 1'b0;
        OP_A     = 32'd0;
        OP_B     = 32'd0;
        OP       = 1'b0;
        last_res = 32'd0;

        #3;
        check("rst.data", IEEE_FORMAT, 32'd0);
        check("rst.valid", {31'd0, OUT_VALID}, 32'd0);
        IN_VALID = 1'b1;
        OP_A     = 32'h3F80_0000;
        OP_B     = 32'h3F80_0000;
        @(posedge CLK);
        #1;
        check("rst_edge.data", IEEE_FORMAT, 32'd0);
        check("rst_edge.valid", {31'd0, OUT_VALID}, 32'd0);
        @(negedge CLK);
        RST      = 1'b1;
        IN_VALID = 1'b0;
        idle(2);

        // Directed vectors from the requirements, back to back.
        apply(32'h3EE0_0000, 32'h3EE0_0000, 1'b0, 32'h3F60_0000, "add_same");
        apply(32'hBEE0_0000, 32'hBEE0_0000, 1'b0, 32'hBF60_0000, "add_same_neg");
        apply(32'h3EE0_0000, 32'hBEE0_0000, 1'b0, 32'h0000_0000, "cancel_pn");
        apply(32'hBEE0_0000, 32'h3EE0_0000, 1'b0, 32'h0000_0000, "cancel_np");
        apply(32'h3EE0_0000, 32'h3EE0_0000, 1'b1, 32'h0000_0000, "sub_self");
        apply(32'h3F00_0000, 32'h3EE0_0000, 1'b0, 32'h3F70_0000, "mix_pp");
        apply(32'h3F00_0000, 32'hBEE0_0000, 1'b0, 32'h3D80_0000, "mix_pn");
        apply(32'hBF00_0000, 32'h3EE0_0000, 1'b0, 32'hBD80_0000, "mix_np");
        apply(32'hBF00_0000, 32'hBEE0_0000, 1'b0, 32'hBF70_0000, "mix_nn");
        apply(32'h3EE0_0000, 32'h3F00_0000, 1'b0, 32'h3F70_0000, "swp_pp");
        apply(32'h3EE0_0000, 32'hBF00_0000, 1'b0, 32'hBD80_0000, "swp_pn");
        apply(32'hBEE0_0000, 32'h3F00_0000, 1'b0, 32'h3D80_0000, "swp_np");
        apply(32'hBEE0_0000, 32'hBF00_0000, 1'b0, 32'hBF70_0000, "swp_nn");
        apply(32'h3F00_0000, 32'h3EE0_0000, 1'b1, 32'h3D80_0000, "sub_op");
        apply(32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, "tie_even");
        apply(32'h3F80_0001, 32'h3380_0000, 1'b0, 32'h3F80_0002, "tie_odd");
        apply(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, "ovf_pos");
        apply(32'hFF7F_FFFF, 32'hFF7F_FFFF, 1'b0, 32'hFF80_0000, "ovf_neg");
        apply(32'h7F7F_FFFF, 32'h7300_0000, 1'b0, 32'h7F80_0000, "ovf_round");
        apply(32'h0000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, "pz_nz");
        apply(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, "nz_nz");
        apply(32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, "pz_sub_pz");
        apply(32'h8000_0000, 32'h0000_0000, 1'b1, 32'h8000_0000, "nz_sub_pz");
        apply(32'h0000_0000, 32'h3F80_0000, 1'b1, 32'hBF80_0000, "zero_sub_b");
        apply(32'h0000_0123, 32'h4040_0000, 1'b0, 32'h4040_0000, "denorm_a");
        apply(32'h3F80_0000, 32'h807F_FFFF, 1'b0, 32'h3F80_0000, "denorm_b");
        apply(32'h0080_0001, 32'h0080_0000, 1'b1, 32'h0000_0000, "underflow");
`ifdef ADDER_SPECIALS_EN
        apply(32'h7FC0_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, "nan_in");
        apply(32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h7F80_0000, "inf_fin");
        apply(32'h7F80_0000, 32'h7F80_0000, 1'b0, 32'h7F80_0000, "inf_inf");
        apply(32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, "inf_sub_inf");
        apply(32'h3F80_0000, 32'hFF80_0000, 1'b0, 32'hFF80_0000, "fin_ninf");
`endif
        idle(2);

        // Asynchronous reset in the middle of a stream.
        apply(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, "pre_rst");
        @(negedge CLK);
        OP_A     = 32'h4000_0000;
        OP_B     = 32'h4000_0000;
        IN_VALID = 1'b1;
        #2;
        RST = 1'b0;
        #1;
        check("rst_mid.data", IEEE_FORMAT, 32'd0);
        check("rst_mid.valid", {31'd0, OUT_VALID}, 32'd0);
        @(posedge CLK);
        #1;
        check("rst_mid_edge.data", IEEE_FORMAT, 32'd0);
        check("rst_mid_edge.valid", {31'd0, OUT_VALID}, 32'd0);
        @(negedge CLK);
        RST      = 1'b1;
        IN_VALID = 1'b0;
        last_res = 32'd0;
        idle(1);
        apply(32'h4000_0000, 32'h4000_0000, 1'b0, 32'h4080_0000, "post_rst");

        // Random operands in several classes.
        for (int i = 0; i < 400; i++) begin
            k = int'($urandom_range(3, 0));
            case (k)
                0: begin
                    a = rand_fp(0, 254);
                    b = rand_fp(0, 254);
                end
                1: begin
                    e = int'($urandom_range(253, 1));
                    a = $urandom;
                    a[30:23] = e[7:0];
                    b = $urandom;
                    b[30:23] = e[7:0] + {7'd0, b[0]};
                end
                2: begin
                    a = rand_fp(200, 254);
                    b = rand_fp(200, 254);
                end
                default: begin
                    a = rand_fp(1, 254);
                    b = $urandom;
                    b[30:23] = 8'd0;
                    if (b[1]) begin
                        b[0] = 1'b0;
                        {a, b} = {b, a};
                    end
                end
            endcase
            op = $urandom_range(1, 0) != 0;
            apply_ref(a, b, op, "rand");
            if ($urandom_range(7, 0) == 0) idle(1);
        end
        idle(1);

        check("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/adder_fp32.md
ADDER_FP32 -- requirements
Module: adder_fp32

Interface
REQ-001 The block SHALL have no parameters; the format is fixed at IEEE-754 binary32.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset: CLK  input  1  rising-edge clock for all state.
REQ-003 RST  input  1  asynchronous active-low reset.
REQ-004 OP_A  input  32  operand A, IEEE-754 single precision.
REQ-005 OP_B  input  32  operand B, IEEE-754 single precision.
REQ-006 OP  input  1  operation select: 0 = A+B, 1 = A-B.
REQ-007 IN_VALID  input  1  operands and OP are valid this cycle.
REQ-008 IEEE_FORMAT  output  32  registered binary32 result.
REQ-009 OUT_VALID  output  1  IEEE_FORMAT holds a new result this cycle.

Function
REQ-010 The block SHALL compute OP_A + OP_B when OP=0 and OP_A - OP_B when OP=1 (OP=1 inverts B's sign bit before the add).
REQ-011 Latency SHALL be exactly 1 cycle: operands sampled at a rising CLK with IN_VALID=1 SHALL appear on IEEE_FORMAT with OUT_VALID=1 after that edge.
REQ-012 With IN_VALID=0 at an edge, OUT_VALID SHALL go 0 and IEEE_FORMAT SHALL hold its previous value; a new operation SHALL be accepted every cycle (no back-pressure).
REQ-013 Datapath: unpack sign/exponent/mantissa with hidden 1; swap so the larger magnitude is operand L; right-shift the smaller mantissa by the exponent difference, keeping guard, round and sticky bits (shift >= 26 leaves only sticky).
REQ-014 Equal signs SHALL add magnitudes; a carry-out SHALL shift right by 1 and increment the exponent.
REQ-015 Differing signs SHALL subtract smaller from larger magnitude; the result SHALL be left-normalized via leading-zero count, decrementing the exponent accordingly.
REQ-016 Result sign SHALL be the sign of the larger-magnitude operand; on equal magnitudes with differing signs, the result SHALL be exactly +0 (0x00000000).
REQ-017 Rounding SHALL be round-to-nearest, ties-to-even; mantissa overflow from rounding SHALL renormalize and increment the exponent.
REQ-018 Denormal inputs SHALL be treated as signed zero; results whose exponent underflows (< 1) SHALL flush to +0.
REQ-019 A zero operand SHALL return the other operand (with OP applied to B's sign); +0 + -0 SHALL give +0, -0 + -0 SHALL give -0.
REQ-020 Exponent overflow (>= 255) SHALL produce signed infinity (exponent 0xFF, mantissa 0).

Reset
REQ-021 While RST=0, IEEE_FORMAT SHALL be 0x00000000 and OUT_VALID 0, immediately and independent of CLK.
REQ-022 An operation in flight when RST asserts SHALL be discarded; the first valid input after RST deasserts SHALL produce a result with normal 1-cycle latency.

Configuration
REQ-023 Macro ADDER_SPECIALS_EN defined: NaN on either input SHALL yield 0x7FC00000; Inf+finite SHALL yield that Inf; Inf+Inf same sign SHALL yield that Inf; Inf-Inf SHALL yield 0x7FC00000.
REQ-024 Macro ADDER_SPECIALS_EN undefined: no NaN/Inf detection logic; exponent 0xFF inputs SHALL be processed as ordinary finite values (result then undefined by this spec); REQ-020 overflow still applies.

Verification
REQ-025 OP_A=0x3EE00000, OP_B=0x3EE00000, OP=0 -> 0x3F600000; negated both -> 0xBF600000.
REQ-026 OP_A=0x3EE00000, OP_B=0xBEE00000, OP=0 -> 0x00000000; swapped signs -> 0x00000000; OP_A=OP_B=0x3EE00000, OP=1 -> 0x00000000.
REQ-027 OP_A=0x3F000000, OP_B=0x3EE00000, OP=0 -> 0x3F700000; 0x3F000000 + 0xBEE00000 -> 0x3D800000; 0xBF000000 + 0x3EE00000 -> 0xBD800000; 0xBF000000 + 0xBEE00000 -> 0xBF700000.
REQ-028 Operand order swapped (0x3EE00000 with 0x3F000000 / 0xBF000000, and negated A) -> 0x3F700000, 0xBD800000, 0x3D800000, 0xBF700000 respectively; OP=1 with 0x3F000000, 0x3EE00000 -> 0x3D800000.
REQ-029 Rounding/overflow: 0x3F800000 + 0x33800000 -> 0x3F800000 (tie to even); 0x3F800001 + 0x33800000 -> 0x3F800002; 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000.
REQ-030 Timing/reset: back-to-back IN_VALID pulses give results on consecutive cycles with OUT_VALID=1; asserting RST mid-stream forces IEEE_FORMAT=0x00000000, OUT_VALID=0 asynchronously.
